udp_cmd_rx: RTL and testbench

- Command-frame receiver and handshake initiator on the UDP-RX leg of the control state machine.
- Parses the byte stream delivered by the MAC receive path and validates framing, length and checksum.
- Latches each good command, then drives fs_udp_rx until the control block answers with fd_udp_rx.
- The control block reads the latched command and payload while the handshake is open.

---
 rtl/cs_pkg.sv | 33 +++
 rtl/cs_hs_init.sv | 53 +++++
 rtl/udp_cmd_rx.sv | 154 +++++++++++++++
 tb/tb_udp_cmd_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared encodings and constants for the control-sequencer command path.
// Holds the parser/handshake state types, default sync bytes and command codes.
package cs_pkg;

    typedef enum logic [2:0] {
        P_IDLE,
        P_H1,
        P_CMD,
        P_LEN,
        P_PAY,
        P_CSUM,
        P_SKIP
    } parse_state_t;

    typedef enum logic [1:0] {
        H_IDLE,
        H_REQ,
        H_WAIT
    } hs_state_t;

    localparam logic [7:0] HDR0_DEF = 8'h55;
    localparam logic [7:0] HDR1_DEF = 8'hAA;

    localparam logic [7:0] CMD_ADC_CHECK = 8'h01;
    localparam logic [7:0] CMD_ADC_CONF  = 8'h02;
    localparam logic [7:0] CMD_ADC_READ  = 8'h03;
    localparam logic [7:0] CMD_ADC_FIFO  = 8'h04;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cs_hs_init.sv
// Generic four-phase fs/fd initiator: raises fs on start, drops it once fd is
// seen, then waits for fd to fall before accepting the next start.
//
// state  | meaning
// H_IDLE | no request open, start accepted
// H_REQ  | fs held high until fd=1 is sampled
// H_WAIT | fs low, waiting for fd to return to 0
module cs_hs_init
    import cs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic fd,
    output logic fs,
    output logic idle
);

    hs_state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= H_IDLE;
            fs    <= 1'b0;
        end else begin
            case (state)
                H_IDLE: begin
                    if (start) begin
                        state <= H_REQ;
                        fs    <= 1'b1;
                    end
                end
                H_REQ: begin
                    if (fd) begin
                        state <= H_WAIT;
                        fs    <= 1'b0;
                    end
                end
                H_WAIT: begin
                    if (!fd) state <= H_IDLE;
                end
                default: begin
                    state <= H_IDLE;
                    fs    <= 1'b0;
                end
            endcase
        end
    end

    // Decoded from the registered state so a same-cycle H_WAIT exit still reads busy.
    assign idle = (state == H_IDLE);

endmodule

// File: rtl/udp_cmd_rx.sv
// UDP command-frame receiver: parses HDR0 HDR1 CMD LEN payload CSUM, latches
// good commands and offers them to the control block through fs/fd.
//
// state  | meaning
// P_IDLE | hunting for HDR0
// P_H1   | HDR0 seen, expecting HDR1
// P_CMD  | next byte is the command code
// P_LEN  | next byte is the payload length
// P_PAY  | collecting payload bytes
// P_CSUM | next byte is the checksum
// P_SKIP | oversize frame, discarding until rx_last
module udp_cmd_rx
    import cs_pkg::*;
#(
    parameter int         MAX_LEN = 8,
    parameter logic [7:0] HDR0    = HDR0_DEF,
    parameter logic [7:0] HDR1    = HDR1_DEF
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   rx_last,
    output logic                   fs_udp_rx,
    input  logic                   fd_udp_rx,
    output logic [7:0]             cmd_code,
    output logic [7:0]             cmd_len,
    output logic [8*MAX_LEN-1:0]   cmd_data,
    output logic [7:0]             err_cnt,
    output logic [7:0]             drop_cnt
);

    localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

    parse_state_t state;
    logic [7:0]   sh_code;
    logic [7:0]   sh_len;
    logic [7:0]   sh_buf [MAX_LEN];
    logic [7:0]   idx;
    logic [7:0]   csum;

    logic frame_good;
    logic err_evt;
    logic hs_idle;
    logic load;

    always_comb begin
        frame_good = 1'b0;
        err_evt    = 1'b0;
        if (rx_valid) begin
            case (state)
                P_CMD:  err_evt = rx_last;
                P_LEN:  err_evt = rx_last || (rx_data > MAX_LEN8);
                P_PAY:  err_evt = rx_last;
                P_CSUM: begin
                    frame_good = (rx_data == csum);
                    err_evt    = (rx_data != csum);
                end
                default: ;
            endcase
        end
    end

    assign load = frame_good && hs_idle;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state   <= P_IDLE;
            sh_code <= 8'h00;
            sh_len  <= 8'h00;
            idx     <= 8'h00;
            csum    <= 8'h00;
            for (int i = 0; i < MAX_LEN; i++) sh_buf[i] <= 8'h00;
        end else if (rx_valid) begin
            case (state)
                P_IDLE: begin
                    if (rx_data == HDR0) state <= P_H1;
                end
                P_H1: begin
                    if (rx_data == HDR1) begin
                        state <= P_CMD;
                        csum  <= 8'h00;
                    end else if (rx_data != HDR0) begin
                        state <= P_IDLE;
                    end
                end
                P_CMD: begin
                    if (rx_last) begin
                        state <= P_IDLE;
                    end else begin
                        sh_code <= rx_data;
                        csum    <= csum + rx_data;
                        state   <= P_LEN;
                    end
                end
                P_LEN: begin
                    sh_len <= rx_data;
                    csum   <= csum + rx_data;
                    idx    <= 8'h00;
                    if (rx_last)                state <= P_IDLE;
                    else if (rx_data > MAX_LEN8) state <= P_SKIP;
                    else if (rx_data == 8'h00)  state <= P_CSUM;
                    else                        state <= P_PAY;
                end
                P_PAY: begin
                    if (rx_last) begin
                        state <= P_IDLE;
                    end else begin
                        for (int i = 0; i < MAX_LEN; i++)
                            if (idx == 8'(i)) sh_buf[i] <= rx_data;
                        csum <= csum + rx_data;
                        if (idx == sh_len - 8'd1) state <= P_CSUM;
                        else                      idx   <= idx + 8'd1;
                    end
                end
                P_CSUM: state <= P_IDLE;
                P_SKIP: begin
                    if (rx_last) state <= P_IDLE;
                end
                default: state <= P_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cmd_code <= 8'h00;
            cmd_len  <= 8'h00;
            cmd_data <= '0;
            err_cnt  <= 8'h00;
            drop_cnt <= 8'h00;
        end else begin
            if (err_evt) err_cnt <= sat_inc(err_cnt);
            if (frame_good && !hs_idle) drop_cnt <= sat_inc(drop_cnt);
            if (load) begin
                cmd_code <= sh_code;
                cmd_len  <= sh_len;
                // Stale shadow bytes beyond this frame's length are masked off here.
                for (int i = 0; i < MAX_LEN; i++)
                    cmd_data[8*i +: 8] <= (8'(i) < sh_len) ? sh_buf[i] : 8'h00;
            end
        end
    end

    cs_hs_init u_hs (
        .clk   (sys_clk),
        .rst   (rst),
        .start (load),
        .fd    (fd_udp_rx),
        .fs    (fs_udp_rx),
        .idle  (hs_idle)
    );

endmodule

// File: tb/tb_udp_cmd_rx.sv
// Directed bench for udp_cmd_rx: hand-built frames with hand-computed
// checksums and expected latched values.
module tb_udp_cmd_rx;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_last;
    logic        fs_udp_rx;
    logic        fd_udp_rx;
    logic [7:0]  cmd_code;
    logic [7:0]  cmd_len;
    logic [63:0] cmd_data;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] seq[$];

    always #5 sys_clk = ~sys_clk;

    udp_cmd_rx #(.MAX_LEN(8)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_last   (rx_last),
        .fs_udp_rx (fs_udp_rx),
        .fd_udp_rx (fd_udp_rx),
        .cmd_code  (cmd_code),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .err_cnt   (err_cnt),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_last  = last;
        tick();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic send_seq();
        for (int i = 0; i < seq.size(); i++) send(seq[i], i == seq.size() - 1);
    endtask

    task automatic close_hs();
        fd_udp_rx = 1'b1;
        tick();
        fd_udp_rx = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0; fd_udp_rx = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        rst = 1'b0;

        check("rst_fs", fs_udp_rx, 0);
        check("rst_code", cmd_code, 0);
        check("rst_len", cmd_len, 0);
        check("rst_data", cmd_data, 0);
        check("rst_err", err_cnt, 0);
        check("rst_drop", drop_cnt, 0);

        // 02+02+10+20 = 34
        seq = '{8'h55, 8'hAA, 8'h02, 8'h02, 8'h10, 8'h20, 8'h34};
        send_seq();
        check("good_fs", fs_udp_rx, 1);
        check("good_code", cmd_code, 8'h02);
        check("good_len", cmd_len, 8'h02);
        check("good_data", cmd_data, 64'h2010);
        fd_udp_rx = 1'b1;
        tick();
        check("good_fs_drop", fs_udp_rx, 0);
        fd_udp_rx = 1'b0;
        tick();

        seq = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h00};
        send_seq();
        tick();
        check("badcs_fs", fs_udp_rx, 0);
        check("badcs_err", err_cnt, 1);

        seq = '{8'h55, 8'hAA, 8'h05, 8'h09};
        for (int i = 0; i < 12; i++) seq.push_back(8'h00);
        send_seq();
        check("oversize_err", err_cnt, 2);
        check("oversize_fs", fs_udp_rx, 0);
        // 01+01+7E = 80
        seq = '{8'h55, 8'hAA, 8'h01, 8'h01, 8'h7E, 8'h80};
        send_seq();
        check("after_skip_fs", fs_udp_rx, 1);
        check("after_skip_code", cmd_code, 8'h01);
        check("after_skip_data", cmd_data, 64'h7E);
        close_hs();

        seq = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h05};
        send_seq();
        check("abort_err", err_cnt, 3);
        check("abort_fs", fs_udp_rx, 0);

        // frame A: 03+01+11 = 15
        seq = '{8'h55, 8'hAA, 8'h03, 8'h01, 8'h11, 8'h15};
        send_seq();
        check("a_fs", fs_udp_rx, 1);
        seq = '{8'h55, 8'hAA, 8'h04, 8'h00, 8'h04};
        send_seq();
        check("b_drop", drop_cnt, 1);
        check("b_code_is_a", cmd_code, 8'h03);
        check("b_data_is_a", cmd_data, 64'h11);
        check("b_fs_held", fs_udp_rx, 1);
        close_hs();
        // frame C: 02+01+22 = 25
        seq = '{8'h55, 8'hAA, 8'h02, 8'h01, 8'h22, 8'h25};
        send_seq();
        check("c_fs", fs_udp_rx, 1);
        check("c_code", cmd_code, 8'h02);
        check("c_data", cmd_data, 64'h22);
        close_hs();

        seq = '{8'h55, 8'h55, 8'hAA, 8'h03, 8'h00, 8'h03};
        send_seq();
        check("sync_fs", fs_udp_rx, 1);
        check("sync_code", cmd_code, 8'h03);
        check("sync_len", cmd_len, 8'h00);
        check("sync_data", cmd_data, 64'h0);
        close_hs();

        // 07+08+(1+..+8=24h) = 33h
        seq = '{8'h55, 8'hAA, 8'h07, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08, 8'h33};
        send_seq();
        check("max_fs", fs_udp_rx, 1);
        check("max_len", cmd_len, 8'h08);
        check("max_data", cmd_data, 64'h0807060504030201);
        check("max_err", err_cnt, 3);
        close_hs();

        fd_udp_rx = 1'b1;
        tick();
        tick();
        check("fd_idle_fs", fs_udp_rx, 0);
        fd_udp_rx = 1'b0;
        tick();

        seq = '{8'h55, 8'hAA, 8'h01, 8'h01, 8'h7E, 8'h80};
        send_seq();
        fd_udp_rx = 1'b1;
        tick();
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h04, 1'b0);
        send(8'h00, 1'b0);
        fd_udp_rx = 1'b0;
        send(8'h04, 1'b1);
        check("wait_exit_drop", drop_cnt, 2);
        check("wait_exit_fs", fs_udp_rx, 0);
        check("wait_exit_code", cmd_code, 8'h01);
        tick();
        seq = '{8'h55, 8'hAA, 8'h02, 8'h01, 8'h22, 8'h25};
        send_seq();
        check("post_wait_fs", fs_udp_rx, 1);
        check("post_wait_code", cmd_code, 8'h02);
        close_hs();

        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h01, 1'b0);
        rst = 1'b1;
        tick();
        check("rpay_fs", fs_udp_rx, 0);
        check("rpay_code", cmd_code, 0);
        check("rpay_len", cmd_len, 0);
        check("rpay_data", cmd_data, 0);
        check("rpay_err", err_cnt, 0);
        check("rpay_drop", drop_cnt, 0);
        rst = 1'b0;
        // 01+02+0A+0B = 18
        seq = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h0A, 8'h0B, 8'h18};
        send_seq();
        check("rpay_next_fs", fs_udp_rx, 1);
        check("rpay_next_data", cmd_data, 64'h0B0A);

        rst = 1'b1;
        tick();
        check("rreq_fs", fs_udp_rx, 0);
        check("rreq_code", cmd_code, 0);
        check("rreq_data", cmd_data, 0);
        rst = 1'b0;
        seq = '{8'h55, 8'hAA, 8'h03, 8'h00, 8'h03};
        send_seq();
        check("rreq_next_fs", fs_udp_rx, 1);
        check("rreq_next_code", cmd_code, 8'h03);
        close_hs();

        seq = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h00};
        for (int n = 0; n < 256; n++) send_seq();
        tick();
        check("sat_err", err_cnt, 8'hFF);
        check("sat_drop", drop_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
